// File: rtl/rst_seq_if.sv
// Board-side reset/lock signals exchanged between the reset sequencer and its surroundings.
// The DUT is the slave; the environment driving switch/lock is the master.
interface rst_seq_if;
    logic       reset_sw;
    logic       locked;
    logic       dcm_reset;
    logic       chip_reset;
    logic       run;
    logic       lock_err;
    logic [3:0] retry_cnt;

    modport master (
        output reset_sw, locked,
        input  dcm_reset, chip_reset, run, lock_err, retry_cnt
    );

    modport slave (
        input  reset_sw, locked,
        output dcm_reset, chip_reset, run, lock_err, retry_cnt
    );
endinterface

// File: rtl/rst_seq.sv
// Reset/clock bring-up sequencer on the reference clock: pulses the DCM reset, waits for
// lock with timeout/retry, and releases chip reset once lock has been stable.
module rst_seq #(
    parameter int DEB_CYC     = 16,
    parameter int DCM_RST_CYC = 4,
    parameter int LOCK_TO_CYC = 1024,
    parameter int STABLE_CYC  = 8,
    parameter int CNT_W       = 16
) (
    input  logic      clk,
    input  logic      reset,
    rst_seq_if.slave  bus
);

    localparam logic [1:0] S_DCM_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TO_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);

    logic             sw_m_q, sw_s_q, lk_m_q, lk_s_q;
    logic             sw_deb_q, sw_deb_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_err_q, lock_err_d;
    logic [3:0]       retry_q, retry_d;
    logic             dcm_reset_q, chip_reset_q, run_q;

    // Any cycle where the synchronized level agrees with the accepted one restarts the count.
    always_comb begin
        sw_deb_d  = sw_deb_q;
        deb_cnt_d = '0;
        if (sw_s_q != sw_deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                sw_deb_d = sw_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_err_d = lock_err_q;
        retry_d    = retry_q;
        if (sw_deb_q) begin
            state_d = S_DCM_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_DCM_RST: begin
                    if (cnt_q == DCM_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk_s_q) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d    = S_DCM_RST;
                        cnt_d      = '0;
                        lock_err_d = 1'b1;
                        retry_d    = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lk_s_q) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (!lk_s_q) begin
                        state_d = S_DCM_RST;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    // Outputs decode state_d so they switch on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_m_q       <= 1'b0;
            sw_s_q       <= 1'b0;
            lk_m_q       <= 1'b0;
            lk_s_q       <= 1'b0;
            sw_deb_q     <= 1'b0;
            deb_cnt_q    <= '0;
            state_q      <= S_DCM_RST;
            cnt_q        <= '0;
            lock_err_q   <= 1'b0;
            retry_q      <= 4'd0;
            dcm_reset_q  <= 1'b1;
            chip_reset_q <= 1'b1;
            run_q        <= 1'b0;
        end else begin
            sw_m_q       <= bus.reset_sw;
            sw_s_q       <= sw_m_q;
            lk_m_q       <= bus.locked;
            lk_s_q       <= lk_m_q;
            sw_deb_q     <= sw_deb_d;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lock_err_q   <= lock_err_d;
            retry_q      <= retry_d;
            dcm_reset_q  <= (state_d == S_DCM_RST);
            chip_reset_q <= (state_d != S_RUN);
            run_q        <= (state_d == S_RUN);
        end
    end

    assign bus.dcm_reset  = dcm_reset_q;
    assign bus.chip_reset = chip_reset_q;
    assign bus.run        = run_q;
    assign bus.lock_err   = lock_err_q;
    assign bus.retry_cnt  = retry_q;

endmodule
